// File: rtl/add_reservation_station_if.sv
// Dispatch, broadcast and issue signals of the add-class reservation station.
interface add_reservation_station_if #(
    parameter int unsigned XLEN = 32
);
    // Dispatch from the register alias table
    logic            dispatch_valid;
    logic [1:0]      dispatch_op;
    logic [3:0]      rs1_tag_in;
    logic [XLEN-1:0] rs1_val_in;
    logic [3:0]      rs2_tag_in;
    logic [XLEN-1:0] rs2_val_in;
    logic [3:0]      add_available;

    // Result broadcast buses
    logic [3:0]      broadcast_tag;
    logic [XLEN-1:0] broadcast_value;
    logic [3:0]      mul_broadcast_tag;
    logic [XLEN-1:0] mul_broadcast_value;

    // Issue to the adder ALU
    logic            issue_valid;
    logic            issue_ready;
    logic [3:0]      issue_tag;
    logic [1:0]      issue_op;
    logic [XLEN-1:0] issue_a;
    logic [XLEN-1:0] issue_b;

    logic            overflow;

    // Producer side: RAT, broadcast sources and ALU
    modport master (
        output dispatch_valid, dispatch_op, rs1_tag_in, rs1_val_in, rs2_tag_in, rs2_val_in,
        output broadcast_tag, broadcast_value, mul_broadcast_tag, mul_broadcast_value,
        output issue_ready,
        input  add_available, issue_valid, issue_tag, issue_op, issue_a, issue_b, overflow
    );

    // Reservation station side
    modport slave (
        input  dispatch_valid, dispatch_op, rs1_tag_in, rs1_val_in, rs2_tag_in, rs2_val_in,
        input  broadcast_tag, broadcast_value, mul_broadcast_tag, mul_broadcast_value,
        input  issue_ready,
        output add_available, issue_valid, issue_tag, issue_op, issue_a, issue_b, overflow
    );
endinterface

// File: rtl/add_reservation_station.sv
// Reservation station for add-class instructions: captures renamed operands,
// wakes them from the add and mul broadcast buses and issues ready entries.
module add_reservation_station #(
    parameter int unsigned NUM_ENTRIES = 4,
    parameter int unsigned TAG_BASE    = 1,
    parameter int unsigned XLEN        = 32
) (
    input logic                       clk,
    input logic                       reset,
    add_reservation_station_if.slave  rs
);
    localparam int unsigned TagW = 4;
    localparam int unsigned IdxW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    logic [NUM_ENTRIES-1:0] busy_q, busy_d;
    logic                   overflow_q, overflow_d;
    logic [1:0]             op_q [NUM_ENTRIES];
    logic [1:0]             op_d [NUM_ENTRIES];
    logic [TagW-1:0]        q1_q [NUM_ENTRIES];
    logic [TagW-1:0]        q1_d [NUM_ENTRIES];
    logic [TagW-1:0]        q2_q [NUM_ENTRIES];
    logic [TagW-1:0]        q2_d [NUM_ENTRIES];
    logic [XLEN-1:0]        v1_q [NUM_ENTRIES];
    logic [XLEN-1:0]        v1_d [NUM_ENTRIES];
    logic [XLEN-1:0]        v2_q [NUM_ENTRIES];
    logic [XLEN-1:0]        v2_d [NUM_ENTRIES];

    logic                   alloc_found;
    logic [IdxW-1:0]        alloc_idx;
    logic [NUM_ENTRIES-1:0] ready;
    logic                   iss_found;
    logic [IdxW-1:0]        iss_idx;

    // Resolve an operand {tag, value}: a zero tag keeps the value, otherwise the
    // add bus has priority over the mul bus; no match keeps waiting on the tag.
    function automatic logic [TagW+XLEN-1:0] capture(
        input logic [TagW-1:0] tag,
        input logic [XLEN-1:0] val,
        input logic [TagW-1:0] btag,
        input logic [XLEN-1:0] bval,
        input logic [TagW-1:0] mtag,
        input logic [XLEN-1:0] mval
    );
        logic [TagW+XLEN-1:0] r;
        r = {tag, val};
        if (tag != '0) begin
            if (tag == btag) begin
                r = {TagW'(0), bval};
            end else if (tag == mtag) begin
                r = {TagW'(0), mval};
            end
        end
        return r;
    endfunction

    // Lowest free entry for dispatch and lowest ready entry for issue
    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        iss_found   = 1'b0;
        iss_idx     = '0;
        ready       = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            ready[i] = busy_q[i] && (q1_q[i] == '0) && (q2_q[i] == '0);
            if (!busy_q[i] && !alloc_found) begin
                alloc_found = 1'b1;
                alloc_idx   = IdxW'(i);
            end
            if (ready[i] && !iss_found) begin
                iss_found = 1'b1;
                iss_idx   = IdxW'(i);
            end
        end
    end

    // Outputs are derived from registered state only; idle issue drives zeros
    always_comb begin
        rs.add_available = alloc_found ? TagW'(TAG_BASE + alloc_idx) : '0;
        rs.issue_valid   = iss_found;
        rs.issue_tag     = iss_found ? TagW'(TAG_BASE + iss_idx) : '0;
        rs.issue_op      = iss_found ? op_q[iss_idx] : '0;
        rs.issue_a       = iss_found ? v1_q[iss_idx] : '0;
        rs.issue_b       = iss_found ? v2_q[iss_idx] : '0;
        rs.overflow      = overflow_q;
    end

    // Next state: wakeup, issue retirement, then dispatch into a pre-edge free entry
    always_comb begin
        busy_d     = busy_q;
        overflow_d = overflow_q;
        op_d       = op_q;
        q1_d       = q1_q;
        q2_d       = q2_q;
        v1_d       = v1_q;
        v2_d       = v2_q;

        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (busy_q[i]) begin
                {q1_d[i], v1_d[i]} = capture(q1_q[i], v1_q[i], rs.broadcast_tag,
                                             rs.broadcast_value, rs.mul_broadcast_tag,
                                             rs.mul_broadcast_value);
                {q2_d[i], v2_d[i]} = capture(q2_q[i], v2_q[i], rs.broadcast_tag,
                                             rs.broadcast_value, rs.mul_broadcast_tag,
                                             rs.mul_broadcast_value);
            end
        end

        if (iss_found && rs.issue_ready) begin
            busy_d[iss_idx] = 1'b0;
        end

        // The allocated entry is free pre-edge, so it never collides with the issue above
        if (rs.dispatch_valid) begin
            if (alloc_found) begin
                busy_d[alloc_idx] = 1'b1;
                op_d[alloc_idx]   = rs.dispatch_op;
                {q1_d[alloc_idx], v1_d[alloc_idx]} = capture(rs.rs1_tag_in, rs.rs1_val_in,
                                                             rs.broadcast_tag, rs.broadcast_value,
                                                             rs.mul_broadcast_tag,
                                                             rs.mul_broadcast_value);
                {q2_d[alloc_idx], v2_d[alloc_idx]} = capture(rs.rs2_tag_in, rs.rs2_val_in,
                                                             rs.broadcast_tag, rs.broadcast_value,
                                                             rs.mul_broadcast_tag,
                                                             rs.mul_broadcast_value);
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    // Payload needs no reset: it is only observed through busy entries
    always_ff @(posedge clk) begin
        op_q <= op_d;
        q1_q <= q1_d;
        q2_q <= q2_d;
        v1_q <= v1_d;
        v2_q <= v2_d;
    end
endmodule

// File: tb/tb_add_reservation_station.sv
// Self-checking bench: per-cycle vector table plus scoreboard of issued instructions.
module tb_add_reservation_station;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    add_reservation_station_if #(.XLEN(32)) bus ();

    add_reservation_station #(
        .NUM_ENTRIES(4),
        .TAG_BASE(1),
        .XLEN(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rs(bus)
    );

    typedef struct {
        logic        dv;
        logic [1:0]  op;
        logic [3:0]  t1;
        logic [31:0] v1;
        logic [3:0]  t2;
        logic [31:0] v2;
        logic [3:0]  bt;
        logic [31:0] bv;
        logic [3:0]  mt;
        logic [31:0] mv;
        logic        rdy;
        logic [3:0]  e_avail;
        logic        e_valid;
        logic [3:0]  e_tag;
        logic        e_ovf;
        logic        has_exp;
        logic [3:0]  x_tag;
        logic [1:0]  x_op;
        logic [31:0] x_a;
        logic [31:0] x_b;
    } vec_t;

    typedef struct {
        logic [3:0]  tag;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;

    function automatic vec_t mk(input logic rdy, input logic [3:0] ea, input logic ev,
                                input logic [3:0] et, input logic eo);
        vec_t v;
        v = '{default: '0};
        v.rdy = rdy; v.e_avail = ea; v.e_valid = ev; v.e_tag = et; v.e_ovf = eo;
        return v;
    endfunction

    function automatic vec_t dsp(input vec_t vi, input logic [1:0] op, input logic [3:0] t1,
                                 input logic [31:0] v1, input logic [3:0] t2,
                                 input logic [31:0] v2);
        vec_t v;
        v = vi;
        v.dv = 1'b1; v.op = op; v.t1 = t1; v.v1 = v1; v.t2 = t2; v.v2 = v2;
        return v;
    endfunction

    function automatic vec_t bc(input vec_t vi, input logic [3:0] bt, input logic [31:0] bv,
                                input logic [3:0] mt, input logic [31:0] mv);
        vec_t v;
        v = vi;
        v.bt = bt; v.bv = bv; v.mt = mt; v.mv = mv;
        return v;
    endfunction

    function automatic vec_t ex(input vec_t vi, input logic [3:0] tag, input logic [1:0] op,
                                input logic [31:0] a, input logic [31:0] b);
        vec_t v;
        v = vi;
        v.has_exp = 1'b1; v.x_tag = tag; v.x_op = op; v.x_a = a; v.x_b = b;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    endtask

    task automatic idle_inputs();
        bus.dispatch_valid = 1'b0; bus.dispatch_op = '0;
        bus.rs1_tag_in = '0; bus.rs1_val_in = '0; bus.rs2_tag_in = '0; bus.rs2_val_in = '0;
        bus.broadcast_tag = '0; bus.broadcast_value = '0;
        bus.mul_broadcast_tag = '0; bus.mul_broadcast_value = '0;
        bus.issue_ready = 1'b0;
    endtask

    task automatic check_idle_issue();
        chk("issue_tag_idle", 32'(bus.issue_tag), 32'd0);
        chk("issue_op_idle", 32'(bus.issue_op), 32'd0);
        chk("issue_a_idle", bus.issue_a, 32'd0);
        chk("issue_b_idle", bus.issue_b, 32'd0);
    endtask

    // One cycle: drive at negedge, compare pre-edge outputs, score any accepted issue
    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        cyc++;
        bus.dispatch_valid = v.dv; bus.dispatch_op = v.op;
        bus.rs1_tag_in = v.t1; bus.rs1_val_in = v.v1;
        bus.rs2_tag_in = v.t2; bus.rs2_val_in = v.v2;
        bus.broadcast_tag = v.bt; bus.broadcast_value = v.bv;
        bus.mul_broadcast_tag = v.mt; bus.mul_broadcast_value = v.mv;
        bus.issue_ready = v.rdy;
        if (v.has_exp) sb.push_back('{tag: v.x_tag, op: v.x_op, a: v.x_a, b: v.x_b});
        #1;
        chk("add_available", 32'(bus.add_available), 32'(v.e_avail));
        chk("issue_valid", 32'(bus.issue_valid), 32'(v.e_valid));
        chk("issue_tag", 32'(bus.issue_tag), 32'(v.e_tag));
        chk("overflow", 32'(bus.overflow), 32'(v.e_ovf));
        if (!v.e_valid) check_idle_issue();
        if (bus.issue_valid && bus.issue_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL sb_empty cycle %0d: got issue tag %0d, want no issue",
                         cyc, bus.issue_tag);
            end else begin
                e = sb.pop_front();
                chk("sb_tag", 32'(bus.issue_tag), 32'(e.tag));
                chk("sb_op", 32'(bus.issue_op), 32'(e.op));
                chk("sb_a", bus.issue_a, e.a);
                chk("sb_b", bus.issue_b, e.b);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Single-cycle wakeup and latency vectors
        tbl.push_back(mk(0, 1, 0, 0, 0));
        tbl.push_back(ex(dsp(mk(0, 1, 0, 0, 0), 2'b00, 0, 5, 0, 7), 1, 2'b00, 5, 7));
        tbl.push_back(mk(1, 2, 1, 1, 0));
        tbl.push_back(ex(dsp(mk(0, 1, 0, 0, 0), 2'b01, 6, 0, 0, 3), 1, 2'b01, 32'h20, 3));
        tbl.push_back(bc(mk(0, 2, 0, 0, 0), 0, 0, 6, 32'h20));
        tbl.push_back(mk(1, 2, 1, 1, 0));
        tbl.push_back(ex(bc(dsp(mk(0, 1, 0, 0, 0), 2'b10, 0, 32'hF0, 3, 0), 3, 9, 0, 0),
                         1, 2'b10, 32'hF0, 9));
        tbl.push_back(mk(1, 2, 1, 1, 0));
        tbl.push_back(ex(dsp(mk(0, 1, 0, 0, 0), 2'b11, 7, 0, 8, 0), 1, 2'b11, 32'hAA, 32'hBB));
        tbl.push_back(bc(mk(0, 2, 0, 0, 0), 8, 32'hBB, 7, 32'hAA));
        tbl.push_back(mk(1, 2, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Fill, overflow on fifth dispatch, free entry 2 via mul broadcast
        apply(dsp(mk(0, 1, 0, 0, 0), 2'b00, 9, 0, 0, 1));
        apply(dsp(mk(0, 2, 0, 0, 0), 2'b00, 10, 0, 0, 2));
        apply(dsp(mk(0, 3, 0, 0, 0), 2'b00, 11, 0, 0, 3));
        apply(dsp(mk(0, 4, 0, 0, 0), 2'b00, 12, 0, 0, 4));
        apply(dsp(mk(0, 0, 0, 0, 0), 2'b00, 9, 0, 0, 5));
        apply(ex(bc(mk(0, 0, 0, 0, 1), 0, 0, 10, 32'h100), 2, 2'b00, 32'h100, 2));
        apply(mk(1, 0, 1, 2, 1));
        apply(mk(0, 2, 0, 0, 1));

        // Entries 1 and 3 ready together; lowest index held until accepted
        apply(bc(mk(0, 2, 0, 0, 1), 9, 32'h11, 11, 32'h33));
        apply(ex(mk(0, 2, 1, 1, 1), 1, 2'b00, 32'h11, 1));
        sb.push_back('{tag: 4'd3, op: 2'b00, a: 32'h33, b: 32'd3});
        apply(mk(0, 2, 1, 1, 1));
        apply(mk(1, 2, 1, 1, 1));
        apply(mk(0, 1, 1, 3, 1));
        // Issue of tag 3 and dispatch into freed entry 0 in the same cycle
        apply(ex(dsp(mk(1, 1, 1, 3, 1), 2'b01, 0, 100, 0, 30), 1, 2'b01, 100, 30));
        apply(mk(0, 2, 1, 1, 1));

        // Reset while busy with a pending accept and dispatch: reset wins
        @(negedge clk);
        cyc++;
        reset = 1'b0;
        bus.issue_ready = 1'b1;
        bus.dispatch_valid = 1'b1;
        #1;
        chk("pre_reset_valid", 32'(bus.issue_valid), 32'd1);
        @(negedge clk);
        cyc++;
        reset = 1'b1;
        idle_inputs();
        sb.delete();
        #1;
        chk("rst_add_available", 32'(bus.add_available), 32'd1);
        chk("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        check_idle_issue();

        apply(ex(dsp(mk(0, 1, 0, 0, 0), 2'b11, 0, 32'h0F, 0, 32'hF0), 1, 2'b11, 32'h0F, 32'hF0));
        apply(mk(1, 2, 1, 1, 0));
        apply(mk(0, 1, 0, 0, 0));

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/add_reservation_station.md
Name: add_reservation_station

Overview:
- Downstream consumer of the register alias table for add-class instructions.
- Holds up to NUM_ENTRIES renamed add/sub instructions and advertises a free entry tag (add_available) back to the RAT.
- Captures operand values or tags at dispatch, snoops the add and mul broadcast buses to wake waiting operands, and issues ready instructions to the adder ALU over a valid/ready handshake.

Parameters:
- NUM_ENTRIES, 4, number of station entries; entry i owns tag TAG_BASE+i.
- TAG_BASE, 1, first tag owned by this station; tag 0 is reserved as "no tag / operand valid".
- XLEN, 32, operand width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- dispatch_valid  input  1  RAT presents an add-class instruction this cycle
- dispatch_op  input  2  00 add, 01 sub, 10 and, 11 or
- rs1_tag_in  input  4  source-1 producer tag; 0 = value valid
- rs1_val_in  input  XLEN  source-1 value (used when rs1_tag_in==0)
- rs2_tag_in  input  4  source-2 producer tag
- rs2_val_in  input  XLEN  source-2 value
- add_available  output  4  tag of the entry the next dispatch will occupy; 0 = full
- broadcast_tag  input  4  add-unit result tag; 0 = idle
- broadcast_value  input  XLEN  add-unit result
- mul_broadcast_tag  input  4  mul-unit result tag; 0 = idle
- mul_broadcast_value  input  XLEN  mul-unit result
- issue_valid  output  1  an entry is ready and presented to the ALU
- issue_ready  input  1  ALU accepts this cycle
- issue_tag  output  4  tag of the issued entry (becomes the ALU broadcast tag)
- issue_op  output  2  op of the issued entry
- issue_a  output  XLEN  operand 1
- issue_b  output  XLEN  operand 2
- overflow  output  1  sticky: dispatch attempted while full

Behaviour:
- Per entry: busy, op, q1/v1, q2/v2, where q==0 means v holds the value.
- Reset (reset==0 at clk edge):
  - All busy cleared and overflow cleared.
  - issue_valid=0, issue_tag=0, issue_op=0, issue_a=0, issue_b=0.
  - add_available=TAG_BASE.
  - Reset wins over every simultaneous event. An in-flight, not-yet-accepted issue is discarded.
- add_available (combinational from registered state): tag of the lowest-index non-busy entry; 0 if all entries are busy.
- Dispatch (dispatch_valid=1, add_available!=0):
  - The entry at add_available is written at the clock edge and busy is set.
  - Operand capture per source: if tag==0, store the value. Else if tag matches a nonzero broadcast_tag this same cycle, store broadcast_value with q=0. Else if it matches mul_broadcast_tag, store mul_broadcast_value with q=0. Else store the tag.
- Dispatch while full (add_available==0): instruction dropped, overflow set to 1, state unchanged.
- Wakeup, every cycle, for every busy entry:
  - A source with q!=0 and q==broadcast_tag (nonzero) captures broadcast_value and clears q.
  - Otherwise, if q==mul_broadcast_tag (nonzero), it captures mul_broadcast_value and clears q.
  - Both sources of one entry may wake in the same cycle, from the same or different buses.
- Ready: busy && q1==0 && q2==0, evaluated on registered state. An operand woken at edge N makes the entry ready during cycle N+1 at the earliest; there is no same-cycle bypass into issue.
- Issue select: the lowest-index ready entry drives issue_valid/tag/op/a/b combinationally.
  - issue_a=v1, issue_b=v2, issue_tag=TAG_BASE+index.
  - When issue_valid=0, issue_tag=0 and the data outputs are 0.
- Handshake:
  - On issue_valid && issue_ready at an edge, the selected entry's busy clears. It is reusable by dispatch from the next cycle (add_available reflects the freed entry next cycle).
  - Without issue_ready, the presented entry stays busy. Outputs may switch to a lower-index entry that became ready; no in-order guarantee is given.
- A dispatch and an issue in the same cycle are independent. Dispatch never targets the entry being freed in that same cycle, because add_available is computed from pre-edge busy.
- Tags outside TAG_BASE..TAG_BASE+NUM_ENTRIES-1 on the broadcast buses are legal and are treated like any other tag for matching.
- Latency: dispatch with both operands valid at edge N → issue_valid high in cycle N+1.

Test Plan:
- Reset then idle → add_available=1, issue_valid=0, overflow=0. Dispatch add with rs1_val=5, rs2_val=7, both tags 0 → next cycle issue_valid=1, issue_tag=1, issue_a=5, issue_b=7, issue_op=00.
- Dispatch with rs1_tag=6, issue_ready=0 → no issue. Next cycle mul_broadcast_tag=6, value=0x20 → following cycle issue_a=0x20, issue_valid=1.
- Dispatch with rs2_tag=3 while broadcast_tag=3, broadcast_value=9 in the same cycle → entry captures 9 and issues next cycle with issue_b=9.
- Four dispatches with unresolved tags → add_available=0. Fifth dispatch → dropped, overflow=1 and stays 1. Broadcast resolves entry 2; accept its issue → add_available=2 the cycle after.
- Entries 1 and 3 both ready, issue_ready=0 for 2 cycles → issue_tag stays 1. issue_ready=1 → tag 1 accepted, then issue_tag=3 next cycle.
- reset=0 asserted while entries are busy and issue_valid=1 → after the edge all outputs are at reset values and add_available=1.
